sr_ff_exerciser: RTL and testbench
==================================

# sr_ff_exerciser

Synthesizable stimulus-and-check engine for a clocked SR flip-flop. It drives S/R into the flip-flop from a fixed vector sequence, samples Q/Qn back, compares them against an internal reference model, and reports pass/fail. It sits beside the gate-level SR flip-flop as the other end of its S/R/Q/Qn interface, so the flop can be exercised in hardware or on-chip without a behavioural testbench.

## Interface
Parameters:
- NUM_VEC, 8: number of table vectors applied per run (legal range 1..8).

Ports:
- clk  in  1  single clock; the flip-flop under test is clocked by the same clk, rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  one-cycle request to begin a run; ignored while busy.
- q_in  in  1  Q from the flip-flop under test.
- qn_in  in  1  Qn from the flip-flop under test.
- s_out  out  1  S drive to the flip-flop (registered).
- r_out  out  1  R drive to the flip-flop (registered).
- busy  out  1  run in progress.
- done  out  1  run complete; held until next start or reset.
- pass  out  1  done and err_count == 0.
- err_count  out  4  mismatches in the current or last run.
- vec_idx  out  3  index of the vector currently applied.

## Operation
- Vector table {S,R}, index 0..7: 01, 10, 00, 01, 00, 10, 11, 01. Only indices 0..NUM_VEC-1 are used.
- Reference model: exp_q and exp_valid registers.
  - 10 sets exp_q=1, exp_valid=1.
  - 01 sets exp_q=0, exp_valid=1.
  - 00 holds both registers.
  - 11 clears exp_valid, because the forbidden state's result is undefined.
- exp_valid resets to 0. The model updates when a vector is checked.
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
  - IDLE: on start=1, go to APPLY with vec_idx=0. err_count and done clear, busy sets.
  - APPLY: s_out/r_out hold table[vec_idx]; next state is SETTLE.
  - SETTLE: the flop captures S/R on the edge that ends this state; next state is CHECK.
  - CHECK: q_in/qn_in are sampled on the edge that ends CHECK and the model is updated with the current vector.
    - If vec_idx == NUM_VEC-1, go to DONE.
    - Otherwise go to APPLY with vec_idx+1.
  - DONE: busy=0, done=1, s_out=r_out=0. On start=1, behave as IDLE+start.
- Check rule, evaluated in CHECK using the post-update model:
  - Error if q_in == qn_in (complement violation), in any vector.
  - Otherwise, if exp_valid and q_in != exp_q, error.
  - At most one error per vector. err_count increments by 1 per error. It cannot overflow, since NUM_VEC ≤ 8.
  - If the vector is 11 and exp_valid=0, only the complement check applies.
- start while busy: ignored, with no restart and no counter clear.

## Timing
- Reset values: state IDLE, s_out=0, r_out=0, busy=0, done=0, pass=0, err_count=0, vec_idx=0, exp_q=0, exp_valid=0.
- start high at edge E0:
  - Edge E1 enters APPLY; s_out/r_out show vector 0 from E1.
  - Each vector takes exactly 3 cycles.
  - done rises at edge E0+3·NUM_VEC+1 (edge 25 for NUM_VEC=8). busy falls on the same edge.
- pass is combinational from done and err_count, and is valid the same cycle done rises.
- rst_n low at any edge mid-run: the next state is IDLE and all outputs take reset values at that edge. No partial result is retained.
- rst_n low and start high on the same edge: reset wins.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with start=1 -> all outputs 0, state IDLE, no S/R activity.
- Ideal flop attached, NUM_VEC=8, start pulse at E0:
  - s_out/r_out step through 01,10,00,01,00,10,11,01 (3 cycles each).
  - done=1 at E0+25, err_count=0, pass=1.
- q_in tied 0, qn_in tied 1, NUM_VEC=8 -> errors at vectors 1, 2 and 5; done with err_count=3, pass=0.
- q_in=qn_in=1 tied, NUM_VEC=8 -> complement error on every vector, so err_count=8, pass=0.
- start re-pulsed at vector 3 -> ignored, and the run still finishes at E0+25. Then rst_n=0 during vector 4 of a second run -> IDLE, s_out=r_out=0, busy=0, err_count=0.
- NUM_VEC=1, ideal flop -> only 01 applied, done at E0+4, pass=1. A start in DONE restarts the run and clears done on the next edge.

Source files
------------

// File: rtl/sr_ff_exerciser.sv
// Stimulus-and-check engine for a clocked SR flip-flop: applies a fixed S/R
// vector table, samples Q/Qn back and scores them against a reference model.
module sr_ff_exerciser #(
   parameter int NUM_VEC = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       q_in,
   input  logic       qn_in,
   output logic       s_out,
   output logic       r_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic [2:0] vec_idx
);

   typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

   localparam logic [2:0] LAST_IDX = 3'(NUM_VEC - 1);

   state_t     state_q, state_d;
   logic [2:0] vec_idx_q, vec_idx_d;
   logic [3:0] err_count_q, err_count_d;
   logic       s_q, s_d;
   logic       r_q, r_d;
   logic       exp_q_q, exp_q_d;
   logic       exp_valid_q, exp_valid_d;
   logic [1:0] cur_sr;
   logic       model_q;
   logic       model_valid;
   logic       err_hit;

   function automatic logic [1:0] vec_sr(input logic [2:0] idx);
      logic [1:0] sr;
      case (idx)
         3'd0:    sr = 2'b01;
         3'd1:    sr = 2'b10;
         3'd2:    sr = 2'b00;
         3'd3:    sr = 2'b01;
         3'd4:    sr = 2'b00;
         3'd5:    sr = 2'b10;
         3'd6:    sr = 2'b11;
         3'd7:    sr = 2'b01;
         default: sr = 2'b00;
      endcase
      return sr;
   endfunction

   always_comb begin
      state_d     = state_q;
      vec_idx_d   = vec_idx_q;
      err_count_d = err_count_q;
      s_d         = s_q;
      r_d         = r_q;
      exp_q_d     = exp_q_q;
      exp_valid_d = exp_valid_q;
      cur_sr      = vec_sr(vec_idx_q);
      model_q     = exp_q_q;
      model_valid = exp_valid_q;
      err_hit     = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d      = APPLY;
               vec_idx_d    = 3'd0;
               err_count_d  = 4'd0;
               {s_d, r_d}   = vec_sr(3'd0);
            end
         end
         APPLY:  state_d = SETTLE;
         SETTLE: state_d = CHECK;
         CHECK: begin
            // The check is scored against the model after it absorbs this vector.
            case (cur_sr)
               2'b10: begin
                  model_q     = 1'b1;
                  model_valid = 1'b1;
               end
               2'b01: begin
                  model_q     = 1'b0;
                  model_valid = 1'b1;
               end
               2'b11:   model_valid = 1'b0;
               default: ;
            endcase
            exp_q_d     = model_q;
            exp_valid_d = model_valid;

            if (q_in == qn_in) begin
               err_hit = 1'b1;
            end else if (model_valid && (q_in != model_q)) begin
               err_hit = 1'b1;
            end
            if (err_hit) begin
               err_count_d = err_count_q + 4'd1;
            end

            if (vec_idx_q == LAST_IDX) begin
               state_d = DONE;
               s_d     = 1'b0;
               r_d     = 1'b0;
            end else begin
               state_d    = APPLY;
               vec_idx_d  = vec_idx_q + 3'd1;
               {s_d, r_d} = vec_sr(vec_idx_q + 3'd1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         vec_idx_q   <= 3'd0;
         err_count_q <= 4'd0;
         s_q         <= 1'b0;
         r_q         <= 1'b0;
         exp_q_q     <= 1'b0;
         exp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         vec_idx_q   <= vec_idx_d;
         err_count_q <= err_count_d;
         s_q         <= s_d;
         r_q         <= r_d;
         exp_q_q     <= exp_q_d;
         exp_valid_q <= exp_valid_d;
      end
   end

   assign s_out     = s_q;
   assign r_out     = r_q;
   assign busy      = (state_q == APPLY) || (state_q == SETTLE) || (state_q == CHECK);
   assign done      = (state_q == DONE);
   assign pass      = done && (err_count_q == 4'd0);
   assign err_count = err_count_q;
   assign vec_idx   = vec_idx_q;

endmodule

// File: tb/tb_sr_ff_exerciser.sv
// Directed bench for sr_ff_exerciser: an 8-vector instance with selectable Q/Qn
// source (ideal flop, stuck 0/1, stuck 1/1) and a 1-vector instance with an ideal flop.
module tb_sr_ff_exerciser;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start0, start1;
   logic [1:0] mode;

   logic       s0, r0, busy0, done0, pass0;
   logic [3:0] err0;
   logic [2:0] idx0;
   logic       q0_in, qn0_in, ff0_q;

   logic       s1, r1, busy1, done1, pass1;
   logic [3:0] err1;
   logic [2:0] idx1;
   logic       ff1_q;

   int total_cnt = 0;
   int pass_cnt  = 0;
   int edges;

   logic [1:0] tbl [8] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01};

   always #5 clk = ~clk;

   // mode 0: ideal flop, mode 1: Q stuck 0 / Qn stuck 1, mode 2: both stuck 1
   assign q0_in  = (mode == 2'd0) ? ff0_q  : (mode == 2'd1) ? 1'b0 : 1'b1;
   assign qn0_in = (mode == 2'd0) ? ~ff0_q : 1'b1;

   always @(posedge clk) begin
      if (!rst_n) ff0_q <= 1'b0;
      else if ({s0, r0} == 2'b10) ff0_q <= 1'b1;
      else if ({s0, r0} == 2'b01) ff0_q <= 1'b0;
   end

   always @(posedge clk) begin
      if (!rst_n) ff1_q <= 1'b0;
      else if ({s1, r1} == 2'b10) ff1_q <= 1'b1;
      else if ({s1, r1} == 2'b01) ff1_q <= 1'b0;
   end

   sr_ff_exerciser #(.NUM_VEC(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .q_in(q0_in), .qn_in(qn0_in),
      .s_out(s0), .r_out(r0), .busy(busy0), .done(done0), .pass(pass0),
      .err_count(err0), .vec_idx(idx0)
   );

   sr_ff_exerciser #(.NUM_VEC(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .q_in(ff1_q), .qn_in(~ff1_q),
      .s_out(s1), .r_out(r1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .vec_idx(idx1)
   );

   // Advance n rising edges, then settle to the following falling edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   // Raise start just after edge E0 so it is sampled at E1; returns after E1.
   task automatic pulse_start0();
      @(negedge clk);
      start0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start0 = 1'b0;
   endtask

   task automatic pulse_start1();
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start0 = 1'b1; start1 = 1'b1; mode = 2'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if ({s0, r0, busy0, done0, pass0, err0, idx0} !== 12'h000)
         $display("[TB] FAIL reset_dut0: got %h expected 000", {s0, r0, busy0, done0, pass0, err0, idx0});
      else pass_cnt++;
      total_cnt++;
      if ({s1, r1, busy1, done1, pass1, err1, idx1} !== 12'h000)
         $display("[TB] FAIL reset_dut1: got %h expected 000", {s1, r1, busy1, done1, pass1, err1, idx1});
      else pass_cnt++;
      start0 = 1'b0; start1 = 1'b0; rst_n = 1'b1;
      step(2);
      total_cnt++;
      if ({s0, r0, busy0, done0} !== 4'b0000)
         $display("[TB] FAIL idle_after_reset: got %b expected 0000", {s0, r0, busy0, done0});
      else pass_cnt++;
   endtask

   task automatic test_ideal_run();
      mode = 2'd0;
      pulse_start0();
      for (int k = 0; k < 8; k++) begin
         for (int c = 0; c < 3; c++) begin
            if (!(k == 0 && c == 0)) step(1);
            total_cnt++;
            if ({busy0, done0, idx0, s0, r0} !== {1'b1, 1'b0, 3'(k), tbl[k]})
               $display("[TB] FAIL ideal_vec%0d_cyc%0d: got %b expected %b", k, c,
                        {busy0, done0, idx0, s0, r0}, {1'b1, 1'b0, 3'(k), tbl[k]});
            else pass_cnt++;
         end
      end
      step(1);
      total_cnt++;
      if ({busy0, done0, pass0, s0, r0} !== 5'b01100)
         $display("[TB] FAIL ideal_done_e25: got %b expected 01100", {busy0, done0, pass0, s0, r0});
      else pass_cnt++;
      total_cnt++;
      if (err0 !== 4'd0)
         $display("[TB] FAIL ideal_err_count: got %0d expected 0", err0);
      else pass_cnt++;
   endtask

   task automatic test_stuck_low();
      mode = 2'd1;
      pulse_start0();
      total_cnt++;
      if ({done0, busy0} !== 2'b01)
         $display("[TB] FAIL restart_from_done: got %b expected 01", {done0, busy0});
      else pass_cnt++;
      edges = 1;
      while (!done0 && edges < 40) begin
         step(1);
         edges++;
      end
      total_cnt++;
      if (edges !== 25)
         $display("[TB] FAIL stuck_low_latency: got %0d expected 25", edges);
      else pass_cnt++;
      total_cnt++;
      if ({err0, pass0} !== {4'd3, 1'b0})
         $display("[TB] FAIL stuck_low_result: got err=%0d pass=%b expected err=3 pass=0", err0, pass0);
      else pass_cnt++;
   endtask

   task automatic test_stuck_high();
      mode = 2'd2;
      pulse_start0();
      edges = 1;
      while (!done0 && edges < 40) begin
         step(1);
         edges++;
      end
      total_cnt++;
      if (edges !== 25)
         $display("[TB] FAIL stuck_high_latency: got %0d expected 25", edges);
      else pass_cnt++;
      total_cnt++;
      if ({err0, pass0} !== {4'd8, 1'b0})
         $display("[TB] FAIL stuck_high_result: got err=%0d pass=%b expected err=8 pass=0", err0, pass0);
      else pass_cnt++;
   endtask

   task automatic test_start_ignored();
      mode = 2'd0;
      pulse_start0();
      step(9);
      start0 = 1'b1;
      step(1);
      start0 = 1'b0;
      total_cnt++;
      if ({busy0, done0, idx0, s0, r0} !== {1'b1, 1'b0, 3'd3, 2'b01})
         $display("[TB] FAIL start_while_busy: got %b expected 1001101", {busy0, done0, idx0, s0, r0});
      else pass_cnt++;
      edges = 11;
      while (!done0 && edges < 40) begin
         step(1);
         edges++;
      end
      total_cnt++;
      if (edges !== 25)
         $display("[TB] FAIL ignored_start_latency: got %0d expected 25", edges);
      else pass_cnt++;
      total_cnt++;
      if ({err0, pass0} !== {4'd0, 1'b1})
         $display("[TB] FAIL ignored_start_result: got err=%0d pass=%b expected err=0 pass=1", err0, pass0);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_run();
      mode = 2'd1;
      pulse_start0();
      step(12);
      total_cnt++;
      if ({busy0, idx0, err0} !== {1'b1, 3'd4, 4'd2})
         $display("[TB] FAIL pre_reset_state: got %b expected 11000010", {busy0, idx0, err0});
      else pass_cnt++;
      rst_n = 1'b0;
      step(1);
      total_cnt++;
      if ({s0, r0, busy0, done0, pass0, err0, idx0} !== 12'h000)
         $display("[TB] FAIL mid_run_reset: got %h expected 000", {s0, r0, busy0, done0, pass0, err0, idx0});
      else pass_cnt++;
      rst_n = 1'b1;
      step(2);
      total_cnt++;
      if ({busy0, done0, s0, r0} !== 4'b0000)
         $display("[TB] FAIL idle_after_mid_reset: got %b expected 0000", {busy0, done0, s0, r0});
      else pass_cnt++;
   endtask

   task automatic test_single_vector();
      pulse_start1();
      for (int c = 0; c < 3; c++) begin
         if (c != 0) step(1);
         total_cnt++;
         if ({busy1, done1, idx1, s1, r1} !== 7'b1000001)
            $display("[TB] FAIL nv1_apply_cyc%0d: got %b expected 1000001", c, {busy1, done1, idx1, s1, r1});
         else pass_cnt++;
      end
      step(1);
      total_cnt++;
      if ({busy1, done1, pass1, s1, r1, err1} !== {5'b01100, 4'd0})
         $display("[TB] FAIL nv1_done_e4: got %b expected 011000000", {busy1, done1, pass1, s1, r1, err1});
      else pass_cnt++;
      start1 = 1'b1;
      step(1);
      start1 = 1'b0;
      total_cnt++;
      if ({busy1, done1, s1, r1} !== 4'b1001)
         $display("[TB] FAIL nv1_restart_in_done: got %b expected 1001", {busy1, done1, s1, r1});
      else pass_cnt++;
      step(3);
      total_cnt++;
      if ({done1, pass1} !== 2'b11)
         $display("[TB] FAIL nv1_second_run: got %b expected 11", {done1, pass1});
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_ideal_run();
      test_stuck_low();
      test_stuck_high();
      test_start_ignored();
      test_reset_mid_run();
      test_single_vector();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
